aes_sbox_arbiter: RTL

// - Shares the single 32-bit S-box (4 parallel byte S-boxes) between the encipher round (ENC) and key expansion (KEY).
// - Round-robin arbiter with bounded bursts: grants one requester, feeds its words to the S-box one word per cycle,
//   and returns registered results with a per-requester valid pulse.
// - Sits between aes_encipher_round / key memory and the shared aes_sbox instance.

---
 rtl/aes_sbox_arbiter_if.sv | 36 +++
 rtl/aes_sbox_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/aes_sbox_arbiter_if.sv
// Requester/S-box bundle between the ENC and KEY requesters, the shared S-box and the arbiter.
interface aes_sbox_arbiter_if;
  logic        enc_req;
  logic [31:0] enc_word;
  logic        enc_last;
  logic        enc_gnt;
  logic        enc_res_valid;
  logic        key_req;
  logic [31:0] key_word;
  logic        key_last;
  logic        key_gnt;
  logic        key_res_valid;
  logic [31:0] res;
  logic [31:0] sboxw;
  logic [31:0] new_sboxw;

  // Arbiter side
  modport slave (
    input  enc_req, enc_word, enc_last,
    input  key_req, key_word, key_last,
    input  new_sboxw,
    output enc_gnt, enc_res_valid,
    output key_gnt, key_res_valid,
    output res, sboxw
  );

  // Requester / S-box side
  modport master (
    output enc_req, enc_word, enc_last,
    output key_req, key_word, key_last,
    output new_sboxw,
    input  enc_gnt, enc_res_valid,
    input  key_gnt, key_res_valid,
    input  res, sboxw
  );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// Round-robin arbiter sharing one 32-bit S-box between the encipher round (ENC)
// and key expansion (KEY), with bursts bounded to MAX_BURST words per grant.
module aes_sbox_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  aes_sbox_arbiter_if.slave  bus
);

  localparam int unsigned CTR_W    = 3;
  localparam int unsigned WORD_W   = 32;
  localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_ENC = 2'd1,
    GNT_KEY = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CTR_W-1:0]   burst_ctr;
  logic [CTR_W-1:0]   burst_ctr_n;
  logic               last_owner_key;
  logic               last_owner_key_n;
  logic               accept_enc;
  logic               accept_key;

  // State, burst counter and fairness history
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      burst_ctr      <= '0;
      last_owner_key <= 1'b1;
    end else begin
      state          <= state_n;
      burst_ctr      <= burst_ctr_n;
      last_owner_key <= last_owner_key_n;
    end
  end

  // Arbitration, word acceptance and burst-exit decisions
  always_comb begin
    state_n          = state;
    burst_ctr_n      = burst_ctr;
    last_owner_key_n = last_owner_key;
    accept_enc       = 1'b0;
    accept_key       = 1'b0;
    bus.sboxw        = '0;

    case (state)
      IDLE: begin
        // On a tie the requester that did not own the S-box last wins.
        if (bus.enc_req && (!bus.key_req || last_owner_key)) begin
          state_n = GNT_ENC;
        end else if (bus.key_req) begin
          state_n = GNT_KEY;
        end
      end

      GNT_ENC: begin
        if (bus.enc_req) begin
          bus.sboxw   = bus.enc_word;
          accept_enc  = 1'b1;
          burst_ctr_n = burst_ctr + CTR_W'(1);
          if (bus.enc_last || (burst_ctr == LAST_CTR)) begin
            state_n          = IDLE;
            burst_ctr_n      = '0;
            last_owner_key_n = 1'b0;
          end
        end else begin
          state_n          = IDLE;
          burst_ctr_n      = '0;
          last_owner_key_n = 1'b0;
        end
      end

      GNT_KEY: begin
        if (bus.key_req) begin
          bus.sboxw   = bus.key_word;
          accept_key  = 1'b1;
          burst_ctr_n = burst_ctr + CTR_W'(1);
          if (bus.key_last || (burst_ctr == LAST_CTR)) begin
            state_n          = IDLE;
            burst_ctr_n      = '0;
            last_owner_key_n = 1'b1;
          end
        end else begin
          state_n          = IDLE;
          burst_ctr_n      = '0;
          last_owner_key_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered grants, result capture and per-requester valid pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.enc_gnt       <= 1'b0;
      bus.key_gnt       <= 1'b0;
      bus.enc_res_valid <= 1'b0;
      bus.key_res_valid <= 1'b0;
      bus.res           <= '0;
    end else begin
      bus.enc_gnt       <= (state_n == GNT_ENC);
      bus.key_gnt       <= (state_n == GNT_KEY);
      bus.enc_res_valid <= accept_enc;
      bus.key_res_valid <= accept_key;
      if (accept_enc || accept_key) begin
        bus.res <= WORD_W'(bus.new_sboxw);
      end
    end
  end

endmodule
